sample_ram_slave: RTL and testbench
===================================

SAMPLE_RAM_SLAVE -- requirements
Module: sample_ram_slave

Interface
REQ-001 Parameter DEPTH, default 1024, number of 16-bit sample words; SHALL be a power of two, 16..65536.
REQ-002 Parameter RD_LATENCY, default 2, cycles from read accept to readdatavalid; SHALL be 1..4.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, non-zero seed of the wait-injection LFSR.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 ddr_addr  input  32  sample word address from the master.
REQ-007 ddr_read  input  1  read request.
REQ-008 ddr_write  input  1  write request.
REQ-009 ddr_writedata  input  16 signed  write sample.
REQ-010 ddr_readdata  output  16 signed  read sample, valid only with ddr_readdatavalid.
REQ-011 ddr_readdatavalid  output  1  one-cycle qualifier per returned read.
REQ-012 ddr_waitrequest  output  1  high means the current command is not accepted.
REQ-013 clr  input  1  single-cycle pulse requesting memory clear.
REQ-014 busy  output  1  high while in CLEAR or DRAIN.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 A command SHALL be accepted on a rising edge where (ddr_read or ddr_write) is high and ddr_waitrequest is low.
REQ-017 Word index SHALL be ddr_addr[log2(DEPTH)-1:0]; upper bits are ignored, so addresses wrap modulo DEPTH.
REQ-018 An accepted write SHALL update memory at that edge; an accepted read SHALL return data RD_LATENCY edges later, in order, with one readdatavalid pulse per read and no gaps for back-to-back reads.
REQ-019 A read accepted one cycle after a write to the same word SHALL return the newly written value.
REQ-020 If ddr_read and ddr_write are high together and accepted, the write SHALL be performed, the read dropped (no readdatavalid), and err set.
REQ-021 States: CLEAR, READY, DRAIN. CLEAR writes 0 to word 0..DEPTH-1, one per cycle, then goes to READY. READY serves commands. On clr in READY, go to DRAIN. Leave DRAIN for CLEAR once all in-flight reads have returned.
REQ-022 ddr_waitrequest SHALL be high in CLEAR and DRAIN. It SHALL also be high in READY whenever injection asserts (see Configuration).
REQ-023 clr during CLEAR SHALL restart the clear counter at 0. clr during DRAIN SHALL be ignored.
REQ-024 Reads in flight when clr arrives SHALL still complete with pre-clear data.
REQ-025 ddr_readdata SHALL hold its last value when not valid.

Reset
REQ-026 While rst is low, the state SHALL be CLEAR with the clear counter at 0.
REQ-027 While rst is low: ddr_waitrequest=1, busy=1, ddr_readdatavalid=0, ddr_readdata=0, err=0, read pipeline valid bits=0, LFSR=LFSR_SEED.
REQ-028 Deassertion of rst SHALL start a full clear; the first command is accepted no earlier than DEPTH cycles later.
REQ-029 Memory contents SHALL not be reset directly; the clear sequence is the only initialisation.

Configuration
REQ-030 Macro SAMPLE_RAM_WAIT_INJECT_EN. When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle in READY. ddr_waitrequest SHALL additionally be high when LFSR[1:0]==2'b00.
REQ-031 When SAMPLE_RAM_WAIT_INJECT_EN is undefined, no LFSR exists, and ddr_waitrequest in READY SHALL be 0.

Structure
REQ-032 Package sample_ram_pkg SHALL hold the state enum (CLEAR, READY, DRAIN), the default DEPTH/RD_LATENCY constants and the LFSR tap constant.
REQ-033 Sub-module sample_ram_rdpipe SHALL implement the RD_LATENCY-deep valid/data shift pipeline and report in-flight-empty; the memory array SHALL stay in the top level.

Verification
REQ-034 Reset release with DEPTH=16, no macro -> busy and waitrequest high for exactly 16 cycles; then a read of address 5 returns 0 after RD_LATENCY=2 cycles.
REQ-035 Write addr 0..255 with data = -addr, then 256 back-to-back reads -> readdatavalid high 256 consecutive cycles, data -addr, in order.
REQ-036 Write 16'sh1234 to addr 3, then next cycle read addr 3+DEPTH -> returns 16'sh1234 (wrap plus read-after-write).
REQ-037 Read and write asserted together -> write stored, no readdatavalid for that command, err=1 and stays 1 until reset.
REQ-038 Issue 2 reads, clr pulse on the following cycle -> both reads return old data, busy rises, waitrequest is high for DRAIN plus DEPTH cycles, then all words read 0.
REQ-039 With SAMPLE_RAM_WAIT_INJECT_EN, drive 1000 read attempts with seed ACE1 -> waitrequest pattern matches the reference LFSR model, and every accepted read returns correct data.

Source files
------------

// File: rtl/sample_ram_pkg.sv
// Shared types and constants for the sample RAM slave.
// The optional wait-injection feature is enabled with SAMPLE_RAM_WAIT_INJECT_EN.
package sample_ram_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int          DEFAULT_DEPTH      = 1024;
  localparam int          DEFAULT_RD_LATENCY = 2;
  localparam logic [15:0] DEFAULT_LFSR_SEED  = 16'hACE1;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the shift-left Fibonacci LFSR; feedback enters at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sample_ram_rdpipe.sv
// Read-return pipeline: carries valid/data through LATENCY register stages.
// Data in each stage only moves with a valid bit, so the last stage holds the
// most recently returned sample while idle.
module sample_ram_rdpipe #(
  parameter int LATENCY = 2,
  parameter int W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic signed [W-1:0] out_data,
  output logic                empty
);

  logic [LATENCY-1:0]  v_reg;
  logic signed [W-1:0] d_reg [LATENCY];

  // Shift valid bits every cycle; shift data only alongside a valid bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_reg <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        d_reg[i] <= '0;
      end
    end else begin
      v_reg[0] <= in_valid;
      if (in_valid) begin
        d_reg[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        v_reg[i] <= v_reg[i-1];
        if (v_reg[i-1]) begin
          d_reg[i] <= d_reg[i-1];
        end
      end
    end
  end

  assign out_valid = v_reg[LATENCY-1];
  assign out_data  = d_reg[LATENCY-1];
  assign empty     = ~in_valid & ~(|v_reg);

endmodule

// File: rtl/sample_ram_slave.sv
// Avalon-style sample RAM slave with clear-on-reset, clr-triggered re-clear,
// in-order fixed-latency reads and a sticky protocol-error flag.
// Define SAMPLE_RAM_WAIT_INJECT_EN to add LFSR-driven random waitrequest.
module sample_ram_slave
  import sample_ram_pkg::*;
#(
  parameter int          DEPTH      = DEFAULT_DEPTH,
  parameter int          RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter logic [15:0] LFSR_SEED  = DEFAULT_LFSR_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ddr_addr,
  input  logic               ddr_read,
  input  logic               ddr_write,
  input  logic signed [15:0] ddr_writedata,
  output logic signed [15:0] ddr_readdata,
  output logic               ddr_readdatavalid,
  output logic               ddr_waitrequest,
  input  logic               clr,
  output logic               busy,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);

  logic signed [15:0] mem [DEPTH];
  logic signed [15:0] mem_q;

  state_t             state_reg;
  logic [AW-1:0]      clr_cnt_reg;
  logic               err_reg;
  logic               rd_fire_reg;

  logic [AW-1:0]      addr_idx;
  logic               inject;
  logic               accept;
  logic               wr_fire;
  logic               rd_fire;
  logic               both_fire;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic signed [15:0] mem_wdata;
  logic               pipe_empty;
  logic               unused_addr_bits;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign addr_idx         = ddr_addr[AW-1:0];
  assign unused_addr_bits = ^ddr_addr[31:AW];

`ifdef SAMPLE_RAM_WAIT_INJECT_EN
  logic [15:0] lfsr_reg;

  // LFSR advances only while serving commands, so its sequence is reproducible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (state_reg == READY) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign inject = (lfsr_reg[1:0] == 2'b00);
`else
  localparam logic [15:0] unused_seed = LFSR_SEED;
  assign inject = 1'b0;
`endif

  assign ddr_waitrequest = (state_reg != READY) | inject;
  assign busy            = (state_reg != READY);
  assign err             = err_reg;

  // A simultaneous read+write performs only the write and flags an error.
  assign accept    = (ddr_read | ddr_write) & ~ddr_waitrequest;
  assign wr_fire   = accept & ddr_write;
  assign rd_fire   = accept & ddr_read & ~ddr_write;
  assign both_fire = accept & ddr_read & ddr_write;

  // Single write port shared between the clear sweep and master writes.
  assign mem_we    = (state_reg == CLEAR) | wr_fire;
  assign mem_waddr = (state_reg == CLEAR) ? clr_cnt_reg : addr_idx;
  assign mem_wdata = (state_reg == CLEAR) ? 16'sd0 : ddr_writedata;

  // Block RAM: synchronous write, registered read (no reset on the array).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    mem_q <= mem[addr_idx];
  end

  // Marks that mem_q holds the data of a read accepted on the previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_fire_reg <= 1'b0;
    end else begin
      rd_fire_reg <= rd_fire;
    end
  end

  sample_ram_rdpipe #(
    .LATENCY (RD_LATENCY),
    .W       (16)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire_reg),
    .in_data   (mem_q),
    .out_valid (ddr_readdatavalid),
    .out_data  (ddr_readdata),
    .empty     (pipe_empty)
  );

  // Control FSM: sweep-clear, serve, then drain in-flight reads before re-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (both_fire) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        CLEAR: begin
          if (clr) begin
            clr_cnt_reg <= '0;
          end else if (clr_cnt_reg == AW'(DEPTH - 1)) begin
            clr_cnt_reg <= '0;
            state_reg   <= READY;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        READY: begin
          if (clr) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            clr_cnt_reg <= '0;
            state_reg   <= CLEAR;
          end
        end
        default: begin
          state_reg   <= CLEAR;
          clr_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_ram_slave.sv
// Self-checking bench for sample_ram_slave (DEPTH=256, RD_LATENCY=2).
// With SAMPLE_RAM_WAIT_INJECT_EN defined it also checks the injected wait pattern.
module tb_sample_ram_slave;

  localparam int          DEPTH      = 256;
  localparam int          AW         = $clog2(DEPTH);
  localparam int          RD_LATENCY = 2;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic               clk;
  logic               rst;
  logic [31:0]        ddr_addr;
  logic               ddr_read;
  logic               ddr_write;
  logic signed [15:0] ddr_writedata;
  logic signed [15:0] ddr_readdata;
  logic               ddr_readdatavalid;
  logic               ddr_waitrequest;
  logic               clr;
  logic               busy;
  logic               err;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] model_mem [DEPTH];
  logic signed [15:0] exp_q [$];
  int                 run_len = 0;
  int                 max_run = 0;

  typedef struct {
    bit                 rd;
    bit                 wr;
    logic [31:0]        addr;
    logic signed [15:0] wdata;
    logic signed [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  sample_ram_slave #(
    .DEPTH      (DEPTH),
    .RD_LATENCY (RD_LATENCY),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ddr_addr          (ddr_addr),
    .ddr_read          (ddr_read),
    .ddr_write         (ddr_write),
    .ddr_writedata     (ddr_writedata),
    .ddr_readdata      (ddr_readdata),
    .ddr_readdatavalid (ddr_readdatavalid),
    .ddr_waitrequest   (ddr_waitrequest),
    .clr               (clr),
    .busy              (busy),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Read-return monitor: pops the scoreboard on every returned sample.
  always @(negedge clk) begin
    if (rst === 1'b1 && ddr_readdatavalid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        chk("unexpected_rdv", 32'd1, 32'd0);
      end else begin
        logic signed [15:0] e;
        e = exp_q.pop_front();
        chk("rdata", 32'(ddr_readdata), 32'(e));
      end
    end else begin
      run_len = 0;
    end
  end

  // Drive one command from a negedge, retrying while waitrequest is high.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic signed [15:0] wd, input logic signed [15:0] exp,
                       input bit use_exp);
    bit done = 0;
    int tries = 0;
    ddr_read      = rd;
    ddr_write     = wr;
    ddr_addr      = addr;
    ddr_writedata = wd;
    while (!done) begin
      if (!ddr_waitrequest) begin
        done = 1;
        if (wr) model_mem[addr[AW-1:0]] = wd;
        else if (rd) exp_q.push_back(use_exp ? exp : model_mem[addr[AW-1:0]]);
      end
      @(posedge clk);
      @(negedge clk);
      if (!done) begin
        tries++;
        if (tries > 300) begin
          chk("accept_timeout", 32'd0, 32'd1);
          done = 1;
        end
      end
    end
    $display("txn rd=%0b wr=%0b addr=%h wdata=%h", rd, wr, addr, wd);
  endtask

  task automatic idle();
    ddr_read  = 1'b0;
    ddr_write = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Counts busy cycles from the current negedge; waitrequest must track busy.
  task automatic count_busy(output int n);
    bit wait_ok = 1;
    n = 0;
    while (busy && n < 4 * DEPTH) begin
      if (!ddr_waitrequest) wait_ok = 0;
      n++;
      @(negedge clk);
    end
    chk("wait_during_busy", 32'(wait_ok), 32'd1);
  endtask

  initial begin
    int n;
    int lat;
    logic [15:0] lref;

    rst = 1'b0; clr = 1'b0;
    ddr_addr = '0; ddr_read = 1'b0; ddr_write = 1'b0; ddr_writedata = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'sd0;

    vecs[0] = '{rd:0, wr:1, addr:32'd10,        wdata:16'sh7FFF, exp_rdata:16'sh0000};
    vecs[1] = '{rd:1, wr:0, addr:32'd10,        wdata:16'sh0000, exp_rdata:16'sh7FFF};
    vecs[2] = '{rd:0, wr:1, addr:32'hFFFF_FF0B, wdata:16'sh8000, exp_rdata:16'sh0000};
    vecs[3] = '{rd:1, wr:0, addr:32'd11,        wdata:16'sh0000, exp_rdata:16'sh8000};
    vecs[4] = '{rd:1, wr:0, addr:32'd12,        wdata:16'sh0000, exp_rdata:16'shFFF4};
    vecs[5] = '{rd:0, wr:1, addr:32'h0000_0100, wdata:16'sh0055, exp_rdata:16'sh0000};
    vecs[6] = '{rd:1, wr:0, addr:32'h0000_0200, wdata:16'sh0000, exp_rdata:16'sh0055};
    vecs[7] = '{rd:1, wr:0, addr:32'd255,       wdata:16'sh0000, exp_rdata:16'shFF01};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wait",  32'(ddr_waitrequest),   32'd1);
    chk("rst_busy",  32'(busy),              32'd1);
    chk("rst_rdv",   32'(ddr_readdatavalid), 32'd0);
    chk("rst_rdata", 32'(ddr_readdata),      32'd0);
    chk("rst_err",   32'(err),               32'd0);

    // Reset release: exactly DEPTH clear cycles
    rst = 1'b1;
    count_busy(n);
    chk("clear_cycles", 32'(n), 32'(DEPTH));
`ifndef SAMPLE_RAM_WAIT_INJECT_EN
    chk("ready_wait_low", 32'(ddr_waitrequest), 32'd0);
`endif

    // First read returns cleared data after RD_LATENCY
    issue(1, 0, 32'd5, 16'sd0, 16'sd0, 1);
    idle();
    lat = 0;
    while (!ddr_readdatavalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", 32'(lat), 32'(RD_LATENCY));
    drain();

    // Fill with -addr, then back-to-back reads
    for (int a = 0; a < 256; a++) issue(0, 1, 32'(a), 16'(-a), 16'sd0, 0);
    max_run = 0;
    for (int a = 0; a < 256; a++) issue(1, 0, 32'(a), 16'sd0, 16'sd0, 0);
    idle();
    drain();
`ifndef SAMPLE_RAM_WAIT_INJECT_EN
    chk("b2b_run", 32'(max_run), 32'd256);
`endif

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1);
    end
    idle();
    drain();

    // Wrap plus read-after-write
    issue(0, 1, 32'd3, 16'sh1234, 16'sd0, 0);
    issue(1, 0, 32'(3 + DEPTH), 16'sd0, 16'sh1234, 1);
    idle();
    drain();

    // Read+write together: write kept, read dropped, sticky err
    chk("err_before", 32'(err), 32'd0);
    issue(1, 1, 32'd20, 16'sh0BAD, 16'sd0, 0);
    idle();
    repeat (RD_LATENCY + 3) @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    chk("no_stray_rdv", 32'(exp_q.size()), 32'd0);
    issue(1, 0, 32'd20, 16'sd0, 16'sh0BAD, 1);
    idle();
    drain();

    // Two reads then clr: old data returned, drain then full clear
    issue(1, 0, 32'd1, 16'sd0, 16'shFFFF, 1);
    issue(1, 0, 32'd2, 16'sd0, 16'shFFFE, 1);
    idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    count_busy(n);
    checks++;
    if (n < DEPTH || n > DEPTH + RD_LATENCY + 4) begin
      errors++;
      $display("FAIL clr_busy_len actual=%0d required=%0d..%0d", n, DEPTH, DEPTH + RD_LATENCY + 4);
    end
    drain();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'sd0;
    chk("err_sticky", 32'(err), 32'd1);
    for (int a = 0; a < DEPTH; a++) issue(1, 0, 32'(a), 16'sd0, 16'sd0, 0);
    idle();
    drain();

`ifdef SAMPLE_RAM_WAIT_INJECT_EN
    // Reset again so the LFSR starts from the seed at READY entry
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_err", 32'(err), 32'd0);
    rst = 1'b1;
    count_busy(n);
    chk("clear_cycles2", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'sd0;
    lref = SEED;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic signed [15:0] d;
      a = 32'($urandom_range(0, 2 * DEPTH - 1));
      d = 16'($urandom);
      ddr_addr      = a;
      ddr_writedata = d;
      ddr_write     = (i % 4 == 0);
      ddr_read      = (i % 4 != 0);
      chk("inject_wait", 32'(ddr_waitrequest), 32'(lref[1:0] == 2'b00));
      if (!ddr_waitrequest) begin
        if (i % 4 == 0) model_mem[a[AW-1:0]] = d;
        else exp_q.push_back(model_mem[a[AW-1:0]]);
      end
      @(posedge clk);
      lref = ref_step(lref);
      @(negedge clk);
    end
    idle();
    drain();
`endif

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
